// File: rtl/s100_ex_pkg.sv
// ---------------------------------------------------------------------------
// s100_ex_pkg
// Shared definitions for the S-100 bus exerciser:
//   - address pattern modes (up, down, walking-one, hold)
//   - bus cycle FSM state enum (IDLE, T1, T2, T3)
//   - active-low seven-segment digit patterns (gfedcba) for the mode display
// ---------------------------------------------------------------------------
package s100_ex_pkg;

  // Address pattern selected by the mode input
  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_WALK = 2'd2,
    MODE_HOLD = 2'd3
  } exMode_t;

  // One bus cycle is T1 -> T2 -> T3, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } busState_t;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG7_DIGIT0 = 7'b1000000;
  localparam logic [6:0] SEG7_DIGIT1 = 7'b1111001;
  localparam logic [6:0] SEG7_DIGIT2 = 7'b0100100;
  localparam logic [6:0] SEG7_DIGIT3 = 7'b0110000;

  // Map a mode to its display digit
  function automatic logic [6:0] seg7Digit(input exMode_t m);
    case (m)
      MODE_UP:   seg7Digit = SEG7_DIGIT0;
      MODE_DOWN: seg7Digit = SEG7_DIGIT1;
      MODE_WALK: seg7Digit = SEG7_DIGIT2;
      default:   seg7Digit = SEG7_DIGIT3;
    endcase
  endfunction

endpackage

// File: rtl/s100_prescaler.sv
// ---------------------------------------------------------------------------
// s100_prescaler
// Down-counter that produces a one-clock tick every div_sel+1 clocks.
// Ports:
//   i_clk    in  1      clock, rising edge
//   i_rstN   in  1      synchronous active-low reset (loads div_sel)
//   div_sel  in  DIV_W  reload value; 0 gives a tick on every clock
//   tick     out 1      high for the clock in which the counter sits at 0
// ---------------------------------------------------------------------------
module s100_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic [DIV_W-1:0] div_sel,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;

  // The tick is the zero condition itself, so the clock that reloads is the tick clock
  assign tick = (r_count == '0);

  // Count down to zero, then reload from div_sel
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_count <= div_sel;
    end else if (r_count == '0) begin
      r_count <= div_sel;
    end else begin
      r_count <= r_count - ONE;
    end
  end

endmodule

// File: rtl/s100_bus_exerciser.sv
// ---------------------------------------------------------------------------
// s100_bus_exerciser
// Generates repeating S-100 bus cycles (T1/T2/T3) paced by a prescaler, with
// an address that steps through a selectable pattern after every cycle.
// Optional feature macro: BUS_WRITE_EN (alternate read / write cycles).
// Ports:
//   pll0_2MHz       in   1       sole clock
//   n_reset         in   1       synchronous active-low reset
//   n_boardReset    in   1       push-button reset, combined with n_reset
//   pll0_LOCKED     in   1       PLL lock; low blocks new cycles
//   run             in   1       allows new bus cycles to start
//   mode            in   2       0 up, 1 down, 2 walking-one, 3 hold
//   div_sel         in   DIV_W   tick period minus one
//   S100adr         out  ADDR_W  bus address
//   pSYNC/pSTVAL/pDBIN/n_pWR/sMWRT  out 1  bus strobes (registered)
//   F_add_oe/F_bus_stat_oe/F_bus_ctl_oe out 1  active-low driver enables
//   SBCLEDS         out  8       active-low view of the top address byte
//   seg7            out  7       active-low mode digit
//   seg7_dp         out  1       heartbeat
//   boardActive     out  1       lock status delayed one clock
//   cycle_done      out  1       one-clock pulse after each completed cycle
//   overrun         out  1       sticky: a tick was lost
// ---------------------------------------------------------------------------
module s100_bus_exerciser
  import s100_ex_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DIV_W  = 16,
  parameter int HB_W   = 20
) (
  input  logic              pll0_2MHz,
  input  logic              n_reset,
  input  logic              n_boardReset,
  input  logic              pll0_LOCKED,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div_sel,
  output logic [ADDR_W-1:0] S100adr,
  output logic              pSYNC,
  output logic              pSTVAL,
  output logic              pDBIN,
  output logic              n_pWR,
  output logic              sMWRT,
  output logic              F_add_oe,
  output logic              F_bus_stat_oe,
  output logic              F_bus_ctl_oe,
  output logic [7:0]        SBCLEDS,
  output logic [6:0]        seg7,
  output logic              seg7_dp,
  output logic              boardActive,
  output logic              cycle_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [HB_W:0]     HB_ONE  = {{HB_W{1'b0}}, 1'b1};

  logic              w_rstN;
  logic              w_tick;
  logic              w_start;
  busState_t         r_state;
  exMode_t           r_modeLat;
  logic [ADDR_W-1:0] r_adr;
  logic              r_pending;
  logic              r_overrun;
  logic              r_done;
  logic              r_sync;
  logic              r_stval;
  logic              r_dbin;
  logic              r_enN;
  logic              r_active;
  logic [HB_W:0]     r_hb;
`ifdef BUS_WRITE_EN
  logic              r_odd;
  logic              r_nWr;
  logic              r_mwrt;
`endif

  // Either reset source holds the whole block in reset
  assign w_rstN = n_reset & n_boardReset;

  s100_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk  (pll0_2MHz),
    .i_rstN (w_rstN),
    .div_sel(div_sel),
    .tick   (w_tick)
  );

  // Next address for the latched pattern; walking-one recovers from any
  // non-one-hot value (including zero) by restarting at bit 0
  function automatic logic [ADDR_W-1:0] nextAdr(input exMode_t m,
                                                input logic [ADDR_W-1:0] a);
    case (m)
      MODE_UP:   nextAdr = a + ADR_ONE;
      MODE_DOWN: nextAdr = a - ADR_ONE;
      MODE_WALK: nextAdr = $onehot(a) ? {a[ADDR_W-2:0], a[ADDR_W-1]} : ADR_ONE;
      default:   nextAdr = a;
    endcase
  endfunction

  assign w_start = (r_state == IDLE) && (w_tick || r_pending) && run && pll0_LOCKED;

  // Bus cycle sequencer: strobes are registered alongside the state so each
  // one is valid for exactly the state it belongs to. A tick that lands
  // while a cycle is busy is remembered once; a second one marks overrun.
  always_ff @(posedge pll0_2MHz) begin
    if (!w_rstN) begin
      r_state   <= IDLE;
      r_modeLat <= MODE_UP;
      r_adr     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_done    <= 1'b0;
      r_sync    <= 1'b0;
      r_stval   <= 1'b1;
      r_dbin    <= 1'b0;
`ifdef BUS_WRITE_EN
      r_odd     <= 1'b0;
      r_nWr     <= 1'b1;
      r_mwrt    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= T1;
            r_sync    <= 1'b1;
            r_modeLat <= exMode_t'(mode);
          end
        end
        T1: begin
          r_state <= T2;
          r_sync  <= 1'b0;
          r_stval <= 1'b0;
        end
        T2: begin
          r_state <= T3;
          r_stval <= 1'b1;
`ifdef BUS_WRITE_EN
          if (r_odd) begin
            r_nWr  <= 1'b0;
            r_mwrt <= 1'b1;
          end else begin
            r_dbin <= 1'b1;
          end
`else
          r_dbin  <= 1'b1;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_dbin  <= 1'b0;
          r_adr   <= nextAdr(r_modeLat, r_adr);
          r_done  <= 1'b1;
`ifdef BUS_WRITE_EN
          r_nWr   <= 1'b1;
          r_mwrt  <= 1'b0;
          r_odd   <= ~r_odd;
`endif
        end
      endcase

      if (r_state == IDLE) begin
        if (w_start) begin
          r_pending <= 1'b0;
        end
      end else if (w_tick && run) begin
        if (r_pending) begin
          r_overrun <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  // Driver enables follow lock one clock late; lock status and heartbeat
  always_ff @(posedge pll0_2MHz) begin
    r_active <= pll0_LOCKED;
    if (!w_rstN) begin
      r_enN <= 1'b1;
      r_hb  <= '0;
    end else begin
      r_enN <= ~pll0_LOCKED;
      r_hb  <= r_hb + HB_ONE;
    end
  end

  assign S100adr       = r_adr;
  assign pSYNC         = r_sync;
  assign pSTVAL        = r_stval;
  assign pDBIN         = r_dbin;
`ifdef BUS_WRITE_EN
  assign n_pWR         = r_nWr;
  assign sMWRT         = r_mwrt;
`else
  assign n_pWR         = 1'b1;
  assign sMWRT         = 1'b0;
`endif
  assign F_add_oe      = r_enN;
  assign F_bus_stat_oe = r_enN;
  assign F_bus_ctl_oe  = r_enN;
  assign SBCLEDS       = ~r_adr[ADDR_W-1 -: 8];
  assign seg7          = seg7Digit(exMode_t'(mode));
  assign seg7_dp       = r_hb[HB_W];
  assign boardActive   = r_active;
  assign cycle_done    = r_done;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_s100_bus_exerciser.sv
// ---------------------------------------------------------------------------
// tb_s100_bus_exerciser
// Self-checking bench for s100_bus_exerciser: a cycle-level behavioural model
// is compared against every output on every clock, and directed scenarios
// pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_s100_bus_exerciser;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int HB = 3;
`ifdef BUS_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  logic          pll0_2MHz;
  logic          n_reset, n_boardReset, pll0_LOCKED, run;
  logic [1:0]    mode;
  logic [DW-1:0] div_sel;
  logic [AW-1:0] S100adr;
  logic          pSYNC, pSTVAL, pDBIN, n_pWR, sMWRT;
  logic          F_add_oe, F_bus_stat_oe, F_bus_ctl_oe;
  logic [7:0]    SBCLEDS;
  logic [6:0]    seg7;
  logic          seg7_dp, boardActive, cycle_done, overrun;

  int vectors;
  int errors;

  logic [6:0] segTable [4];

  s100_bus_exerciser #(.ADDR_W(AW), .DIV_W(DW), .HB_W(HB)) dut (
    .pll0_2MHz    (pll0_2MHz),
    .n_reset      (n_reset),
    .n_boardReset (n_boardReset),
    .pll0_LOCKED  (pll0_LOCKED),
    .run          (run),
    .mode         (mode),
    .div_sel      (div_sel),
    .S100adr      (S100adr),
    .pSYNC        (pSYNC),
    .pSTVAL       (pSTVAL),
    .pDBIN        (pDBIN),
    .n_pWR        (n_pWR),
    .sMWRT        (sMWRT),
    .F_add_oe     (F_add_oe),
    .F_bus_stat_oe(F_bus_stat_oe),
    .F_bus_ctl_oe (F_bus_ctl_oe),
    .SBCLEDS      (SBCLEDS),
    .seg7         (seg7),
    .seg7_dp      (seg7_dp),
    .boardActive  (boardActive),
    .cycle_done   (cycle_done),
    .overrun      (overrun)
  );

  // Free-running clock
  initial begin
    pll0_2MHz = 1'b0;
    forever #5 pll0_2MHz = ~pll0_2MHz;
  end

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive all inputs, then hold them for the given number of clocks
  task automatic applyStimulus(input bit nr, input bit nb, input bit lk, input bit rn,
                               input logic [1:0] md, input logic [DW-1:0] dv,
                               input int cycles);
    n_reset      = nr;
    n_boardReset = nb;
    pll0_LOCKED  = lk;
    run          = rn;
    mode         = md;
    div_sel      = dv;
    repeat (cycles) @(negedge pll0_2MHz);
  endtask

  // Address pattern rules in plain arithmetic on a 2^20 address space
  function automatic logic [AW-1:0] modelNext(input logic [1:0] m, input logic [AW-1:0] a);
    longint v;
    longint span;
    span = longint'(1) << AW;
    v    = longint'(a);
    case (m)
      2'd0: v = (v + 1) % span;
      2'd1: v = (v + span - 1) % span;
      2'd2: begin
        if ($countones(a) == 1) v = (v == span / 2) ? 1 : v * 2;
        else v = 1;
      end
      default: v = v;
    endcase
    return AW'(v);
  endfunction

  // Behavioural model: phase 0 is idle, 1..3 are T1..T3
  int            mPhase, oldPhase, mK;
  int unsigned   mHb;
  logic [AW-1:0] mAddr;
  logic [1:0]    mModeLat;
  bit            mPending, oldPending, mOverrun, mDone, mEnN, mOdd, mTick;
  bit            mPrevLocked, modelValid;

  initial begin
    modelValid = 1'b0;
    forever begin
      @(posedge pll0_2MHz);
      if (!n_reset || !n_boardReset) begin
        mPhase = 0; mAddr = '0; mPending = 0; mOverrun = 0; mDone = 0;
        mEnN = 1; mK = 0; mHb = 0; mOdd = 0; mModeLat = 2'd0;
        modelValid = 1'b1;
      end else if (modelValid) begin
        mTick = (mK % (int'(div_sel) + 1)) == int'(div_sel);
        mK++;
        mHb++;
        mDone      = 0;
        mEnN       = !pll0_LOCKED;
        oldPhase   = mPhase;
        oldPending = mPending;
        if (oldPhase == 0) begin
          if ((mTick || oldPending) && run && pll0_LOCKED) begin
            mPhase = 1; mPending = 0; mModeLat = mode;
          end
        end else begin
          if (mTick && run) begin
            if (oldPending) mOverrun = 1;
            else mPending = 1;
          end
          if (oldPhase == 3) begin
            mPhase = 0; mAddr = modelNext(mModeLat, mAddr); mDone = 1; mOdd = !mOdd;
          end else begin
            mPhase = oldPhase + 1;
          end
        end
      end
      mPrevLocked = pll0_LOCKED;
      #1;
      if (modelValid) begin
        logic [AW-1:0] inv;
        bit            wr;
        inv = ~mAddr;
        wr  = (mPhase == 3) && WRITE_EN && mOdd;
        checkOutput("adr",     S100adr, mAddr);
        checkOutput("pSYNC",   pSYNC,   mPhase == 1);
        checkOutput("pSTVAL",  pSTVAL,  mPhase != 2);
        checkOutput("pDBIN",   pDBIN,   (mPhase == 3) && !wr);
        checkOutput("n_pWR",   n_pWR,   !wr);
        checkOutput("sMWRT",   sMWRT,   wr);
        checkOutput("addOe",   F_add_oe,      mEnN);
        checkOutput("statOe",  F_bus_stat_oe, mEnN);
        checkOutput("ctlOe",   F_bus_ctl_oe,  mEnN);
        checkOutput("leds",    SBCLEDS, inv[AW-1 -: 8]);
        checkOutput("seg7",    seg7,    segTable[mode]);
        checkOutput("dp",      seg7_dp, (mHb >> HB) & 1);
        checkOutput("active",  boardActive, mPrevLocked);
        checkOutput("done",    cycle_done,  mDone);
        checkOutput("overrun", overrun,     mOverrun);
      end
    end
  end

  // Directed scenarios with literal expectations
  initial begin
    int seen, lastT, cnt;
    bit found;
    logic [AW-1:0] e;
    vectors = 0;
    errors  = 0;
    segTable[0] = 7'b1000000;
    segTable[1] = 7'b1111001;
    segTable[2] = 7'b0100100;
    segTable[3] = 7'b0110000;

    // Reset state, then counting up with a tick every 4 clocks
    applyStimulus(0, 1, 1, 1, 2'd0, 16'd3, 2);
    checkOutput("rst_adr",   S100adr, 0);
    checkOutput("rst_sync",  pSYNC,   0);
    checkOutput("rst_stval", pSTVAL,  1);
    checkOutput("rst_dbin",  pDBIN,   0);
    checkOutput("rst_nwr",   n_pWR,   1);
    checkOutput("rst_oe",    F_add_oe, 1);
    checkOutput("rst_leds",  SBCLEDS, 8'hFF);
    checkOutput("rst_done",  cycle_done, 0);
    checkOutput("rst_ovr",   overrun, 0);
    n_reset = 1'b1;
    seen = 0; lastT = 0;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(negedge pll0_2MHz);
      if (pSYNC) begin
        checkOutput("up_adr", S100adr, seen);
        if (seen > 0) checkOutput("up_period", c - lastT, 4);
        lastT = c;
        seen++;
      end
    end
    checkOutput("up_cycles", seen, 4);

    // Counting down wraps from zero to all-ones
    applyStimulus(0, 1, 1, 1, 2'd1, 16'd3, 2);
    n_reset = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge pll0_2MHz);
      if (cycle_done) found = 1;
    end
    checkOutput("down_seen", found, 1);
    checkOutput("down_adr",  S100adr, 20'hFFFFF);
    checkOutput("down_leds", SBCLEDS, 8'h00);

    // Walking one from zero: 1, 2, 4 ... 0x80000, then 1 again
    applyStimulus(0, 1, 1, 1, 2'd2, 16'd0, 2);
    n_reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && seen < 21; c++) begin
      @(negedge pll0_2MHz);
      if (cycle_done) begin
        e = 20'd1 << (seen % 20);
        checkOutput("walk_adr", S100adr, e);
        seen++;
      end
    end
    checkOutput("walk_cycles", seen, 21);

    // Tick every clock: overrun appears on the third clock and is sticky
    applyStimulus(0, 1, 1, 1, 2'd3, 16'd0, 2);
    applyStimulus(1, 1, 1, 1, 2'd3, 16'd0, 2);
    checkOutput("ovr_clk2", overrun, 0);
    applyStimulus(1, 1, 1, 1, 2'd3, 16'd0, 1);
    checkOutput("ovr_clk3", overrun, 1);
    applyStimulus(1, 1, 1, 1, 2'd3, 16'd0, 20);
    checkOutput("ovr_sticky", overrun, 1);
    checkOutput("hold_adr",   S100adr, 0);
    applyStimulus(1, 0, 1, 1, 2'd3, 16'd0, 1);
    checkOutput("ovr_brdrst", overrun, 0);

    // Pending survives run=0, and ticks are ignored meanwhile
    applyStimulus(0, 1, 1, 1, 2'd0, 16'd2, 2);
    applyStimulus(1, 1, 1, 1, 2'd0, 16'd2, 12);
    applyStimulus(1, 1, 1, 0, 2'd0, 16'd2, 10);
    applyStimulus(1, 1, 1, 1, 2'd0, 16'd2, 12);

    // Losing lock during T2 lets the cycle finish and blocks further cycles
    applyStimulus(0, 1, 1, 1, 2'd0, 16'd3, 2);
    n_reset = 1'b1;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge pll0_2MHz);
      if (!pSTVAL) found = 1;
    end
    checkOutput("lock_t2_seen", found, 1);
    pll0_LOCKED = 1'b0;
    @(negedge pll0_2MHz);
    checkOutput("lock_t3",  pDBIN, 1);
    checkOutput("lock_oe",  F_bus_ctl_oe, 1);
    @(negedge pll0_2MHz);
    checkOutput("lock_done", cycle_done, 1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pll0_2MHz);
      if (pSYNC) cnt++;
    end
    checkOutput("lock_noT1", cnt, 0);
    checkOutput("lock_oe2",  F_add_oe, 1);
    pll0_LOCKED = 1'b1;
    repeat (20) @(negedge pll0_2MHz);

    // Reset in the middle of a cycle aborts it with no completion pulse
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge pll0_2MHz);
      if (!pSTVAL) found = 1;
    end
    checkOutput("abort_t2_seen", found, 1);
    n_reset = 1'b0;
    @(negedge pll0_2MHz);
    checkOutput("abort_done",  cycle_done, 0);
    checkOutput("abort_stval", pSTVAL, 1);
    checkOutput("abort_adr",   S100adr, 0);
    n_reset = 1'b1;
    repeat (10) @(negedge pll0_2MHz);

    // Mode digit on the display
    for (int m = 0; m < 4; m++) begin
      applyStimulus(1, 1, 1, 0, 2'(m), 16'd3, 2);
      checkOutput("seg7_lit", seg7, segTable[m]);
    end

`ifdef BUS_WRITE_EN
    // First cycle reads, second writes
    applyStimulus(0, 1, 1, 1, 2'd0, 16'd3, 2);
    n_reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 30 && seen < 2; c++) begin
      @(negedge pll0_2MHz);
      if (pDBIN || !n_pWR) begin
        checkOutput("wr_dbin",  pDBIN, seen == 0);
        checkOutput("wr_npwr",  n_pWR, seen == 0);
        checkOutput("wr_smwrt", sMWRT, seen == 1);
        seen++;
      end
    end
    checkOutput("wr_cycles", seen, 2);
`endif

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/s100_bus_exerciser.md
S100_BUS_EXERCISER -- requirements
Module: s100_bus_exerciser

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, S-100 address width (16..24).
REQ-002 The block SHALL have parameter DIV_W, default 16, prescaler reload width.
REQ-003 The block SHALL have parameter HB_W, default 20, heartbeat counter bit index for seg7_dp.
REQ-004 The block SHALL have port pll0_2MHz  in  1  sole clock, all logic on its rising edge.
REQ-005 The block SHALL have port n_reset  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port n_boardReset  in  1  onboard push-button reset, synchronous, active-low, ORed with n_reset.
REQ-007 The block SHALL have port pll0_LOCKED  in  1  PLL lock status.
REQ-008 The block SHALL have port run  in  1  enables starting new bus cycles.
REQ-009 The block SHALL have port mode  in  2  address pattern: 0 up, 1 down, 2 walking-one, 3 hold.
REQ-010 The block SHALL have port div_sel  in  DIV_W  ticks occur every div_sel+1 clocks.
REQ-011 The block SHALL have ports S100adr  out  ADDR_W; pSYNC, pSTVAL, pDBIN, n_pWR, sMWRT  out  1 each.
REQ-012 The block SHALL have ports F_add_oe, F_bus_stat_oe, F_bus_ctl_oe  out  1  active-low driver enables.
REQ-013 The block SHALL have ports SBCLEDS  out  8  active-low; seg7  out  7; seg7_dp, boardActive, cycle_done, overrun  out  1.

Function
REQ-014 Prescaler: down-counter loads div_sel; it issues a one-clock tick on reaching 0 and reloads; div_sel=0 ticks every clock.
REQ-015 FSM states SHALL be IDLE, T1, T2, T3; IDLE->T1 on (tick or pending) while run=1 and pll0_LOCKED=1; T1->T2->T3->IDLE unconditionally, one clock each.
REQ-016 Outputs SHALL be registered: T1 pSYNC=1; T2 pSTVAL=0; T3 pDBIN=1; otherwise pSYNC=0, pSTVAL=1, pDBIN=0, n_pWR=1, sMWRT=0.
REQ-017 On the T3->IDLE edge, S100adr SHALL advance per mode sampled on IDLE->T1, and cycle_done SHALL pulse one clock.
REQ-018 Mode 0: +1, wrapping 2^ADDR_W-1 -> 0. Mode 1: -1, wrapping 0 -> 2^ADDR_W-1. Mode 3: unchanged.
REQ-019 Mode 2: rotate left one bit, MSB -> bit 0; a non-one-hot address (including 0) SHALL load 1 instead.
REQ-020 A tick arriving outside IDLE SHALL set a one-deep pending flag; a tick while pending is already set SHALL set sticky overrun, cleared only by reset.
REQ-021 pending SHALL clear on IDLE->T1; with run=0 ticks SHALL be ignored and pending SHALL be retained.
REQ-022 pll0_LOCKED low SHALL let an active cycle finish, block new cycles, and drive all three enables to 1 the next clock; enables are 0 when locked and out of reset.
REQ-023 boardActive SHALL equal pll0_LOCKED registered one clock.
REQ-024 SBCLEDS SHALL be ~S100adr[ADDR_W-1 -: 8].
REQ-025 seg7 SHALL show the current mode active-low (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000.
REQ-026 seg7_dp SHALL be bit HB_W of a free-running counter that is reset to 0.

Reset
REQ-027 While n_reset=0 or n_boardReset=0 at a clock edge, the block SHALL set S100adr=0, FSM=IDLE, prescaler=div_sel, pending=0, overrun=0, cycle_done=0, and heartbeat=0.
REQ-028 Bus strobes SHALL reset to their inactive values; enables SHALL reset to 1; SBCLEDS SHALL reset to 8'hFF.
REQ-029 Reset mid-cycle SHALL abort to IDLE on that edge, without cycle_done and without an address update.

Configuration
REQ-030 With BUS_WRITE_EN defined, the block SHALL alternate cycles: odd cycles drive n_pWR=0 and sMWRT=1 in T3 instead of pDBIN=1; parity SHALL reset to even.
REQ-031 Without BUS_WRITE_EN, every cycle SHALL be a read, with n_pWR tied 1 and sMWRT tied 0.

Structure
REQ-032 Package s100_ex_pkg SHALL hold the mode encodings, the FSM state enum, and the seg7 digit constants.
REQ-033 The prescaler SHALL be sub-module s100_prescaler (DIV_W, div_sel in, tick out).

Verification
REQ-034 Reset release, div_sel=3, mode 0, run=1: ticks every 4 clocks; T1/T2/T3 strobes each last one clock; addresses run 0,1,2,3.
REQ-035 Mode 1 from reset: the first cycle_done gives S100adr=20'hFFFFF, and SBCLEDS=8'h00.
REQ-036 Mode 2 starting at 0: addresses run 1,2,4 ... 20'h80000, then 1.
REQ-037 div_sel=0: pending sets, overrun sets by the third clock and stays set until n_boardReset=0.
REQ-038 Drop pll0_LOCKED during T2: T3 completes, cycle_done pulses, enables go 1, no new T1 occurs.
REQ-039 BUS_WRITE_EN defined: cycle 0 asserts pDBIN; cycle 1 asserts n_pWR=0 and sMWRT=1 in T3 only.
